// File: rtl/rx_frame_store.sv
// Double-buffered receive frame store: radio words fill the hidden bank; a completed frame swaps banks.
// Display reads have one cycle of latency. There is no backpressure: an aborted frame is dropped and counted.
module rx_frame_store #(
    parameter int FRAME_WORDS = 38400,
    parameter int CNT_W       = 8
) (
    input  logic             Cclk,
    input  logic             rstn,
    input  logic             RxEn,
    input  logic [11:0]      RxData,
    input  logic             RxValid,
    input  logic             RxFrame,
    input  logic [15:0]      RdAdd,
    output logic [11:0]      RdData,
    output logic             DispBank,
    output logic             FrameDone,
    output logic [CNT_W-1:0] FrameCnt,
    output logic [CNT_W-1:0] ErrCnt,
    output logic             Busy
);

    localparam int          AW    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [15:0] LAST  = 16'(FRAME_WORDS - 1);
    localparam logic [16:0] DEPTH = 17'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t        state;
    logic [15:0]   w_add;
    logic [11:0]   bank0 [FRAME_WORDS];
    logic [11:0]   bank1 [FRAME_WORDS];
    logic          start;
    logic          wr_en;
    logic [AW-1:0] wr_add;

    assign start = RxEn & RxValid & RxFrame;
    assign Busy  = (state == RECV);

    // A frame start always lands at word 0, whatever state we are in.
    always_comb begin
        wr_en  = 1'b0;
        wr_add = w_add[AW-1:0];
        case (state)
            RECV: begin
                if (RxEn && RxValid) begin
                    wr_en = 1'b1;
                    if (RxFrame) wr_add = '0;
                end
            end
            default: begin
                if (start) begin
                    wr_en  = 1'b1;
                    wr_add = '0;
                end
            end
        endcase
    end

    always_ff @(posedge Cclk) begin
        if (wr_en) begin
            if (DispBank) bank0[wr_add] <= RxData;
            else          bank1[wr_add] <= RxData;
        end
    end

    // Uses the current DispBank, so a read on the swap edge still sees the old frame.
    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            RdData <= '0;
        end else if ({1'b0, RdAdd} < DEPTH) begin
            RdData <= DispBank ? bank1[RdAdd[AW-1:0]] : bank0[RdAdd[AW-1:0]];
        end else begin
            RdData <= '0;
        end
    end

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            w_add     <= '0;
            DispBank  <= 1'b0;
            FrameDone <= 1'b0;
            FrameCnt  <= '0;
            ErrCnt    <= '0;
        end else begin
            FrameDone <= 1'b0;
            case (state)
                RECV: begin
                    if (!RxEn) begin
                        if (ErrCnt != '1) ErrCnt <= ErrCnt + 1'b1;
                        state <= DROP;
                        w_add <= '0;
                    end else if (RxValid && RxFrame) begin
                        if (ErrCnt != '1) ErrCnt <= ErrCnt + 1'b1;
                        w_add <= 16'd1;
                    end else if (RxValid) begin
                        if (w_add == LAST) begin
                            DispBank  <= ~DispBank;
                            w_add     <= '0;
                            state     <= IDLE;
                            FrameDone <= 1'b1;
                            FrameCnt  <= FrameCnt + 1'b1;
                        end else begin
                            w_add <= w_add + 16'd1;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        w_add <= 16'd1;
                        state <= RECV;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_store.sv
// Randomised bench for rx_frame_store with a frame-level reference model (queue of words per frame).
module tb_rx_frame_store;
    localparam int FW = 40;
    localparam int CW = 8;

    logic          Cclk = 1'b0;
    logic          rstn = 1'b0;
    logic          RxEn = 1'b0;
    logic [11:0]   RxData = '0;
    logic          RxValid = 1'b0;
    logic          RxFrame = 1'b0;
    logic [15:0]   RdAdd = '0;
    logic [11:0]   RdData;
    logic          DispBank;
    logic          FrameDone;
    logic [CW-1:0] FrameCnt;
    logic [CW-1:0] ErrCnt;
    logic          Busy;

    rx_frame_store #(.FRAME_WORDS(FW), .CNT_W(CW)) dut (
        .Cclk(Cclk), .rstn(rstn), .RxEn(RxEn), .RxData(RxData), .RxValid(RxValid),
        .RxFrame(RxFrame), .RdAdd(RdAdd), .RdData(RdData), .DispBank(DispBank),
        .FrameDone(FrameDone), .FrameCnt(FrameCnt), .ErrCnt(ErrCnt), .Busy(Busy)
    );

    always #5 Cclk = ~Cclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a frame is the list of words since the last start.
    bit          m_active = 0;
    logic [11:0] m_cur[$];
    logic [11:0] m_bank [2][FW];
    bit          m_disp = 0;
    int          m_cnt = 0;
    int          m_err = 0;
    bit          m_done = 0;
    int          done_seen = 0;

    task automatic model_reset();
        m_active = 0;
        m_cur.delete();
        m_disp = 0;
        m_cnt = 0;
        m_err = 0;
        m_done = 0;
    endtask

    task automatic step(input bit en, input bit vld, input bit frm, input logic [11:0] d);
        RxEn = en; RxValid = vld; RxFrame = frm; RxData = d;
        @(posedge Cclk);
        #1;
        m_done = 0;
        if (m_active) begin
            if (!en) begin
                if (m_err < 255) m_err++;
                m_active = 0;
                m_cur.delete();
            end else if (vld && frm) begin
                if (m_err < 255) m_err++;
                m_cur.delete();
                m_cur.push_back(d);
            end else if (vld) begin
                m_cur.push_back(d);
                if (m_cur.size() == FW) begin
                    for (int i = 0; i < FW; i++) m_bank[m_disp ? 0 : 1][i] = m_cur[i];
                    m_disp = !m_disp;
                    m_cnt++;
                    m_done = 1;
                    m_active = 0;
                    m_cur.delete();
                end
            end
        end else if (en && vld && frm) begin
            m_active = 1;
            m_cur.delete();
            m_cur.push_back(d);
        end
        if (FrameDone === 1'b1) done_seen++;
    endtask

    task automatic send_frame(input int gap);
        step(1, 1, 1, 12'($urandom));
        for (int k = 1; k < FW; k++) begin
            repeat (gap) step(1, 0, 1'($urandom), 12'($urandom));
            step(1, 1, 0, 12'($urandom));
        end
    endtask

    task automatic rd(input logic [15:0] a);
        RdAdd = a;
        @(posedge Cclk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Cclk);
        #2;
        n_checks++; if (RdData !== 12'h000) begin n_fail++; $display("FAIL reset_rddata: got %h want 000", RdData); end
        n_checks++; if (DispBank !== 1'b0) begin n_fail++; $display("FAIL reset_dispbank: got %b want 0", DispBank); end
        n_checks++; if (FrameDone !== 1'b0) begin n_fail++; $display("FAIL reset_framedone: got %b want 0", FrameDone); end
        n_checks++; if (FrameCnt !== '0) begin n_fail++; $display("FAIL reset_framecnt: got %0d want 0", FrameCnt); end
        n_checks++; if (ErrCnt !== '0) begin n_fail++; $display("FAIL reset_errcnt: got %0d want 0", ErrCnt); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
        @(negedge Cclk);
        rstn = 1'b1;
    endtask

    task automatic test_full_frame();
        int d0 = done_seen;
        step(1, 1, 1, 12'h001);
        for (int k = 2; k <= FW; k++) step(1, 1, 0, 12'(k));
        n_checks++; if (FrameDone !== 1'b1 || m_done != 1) begin n_fail++; $display("FAIL full_done_pulse: got %b want 1", FrameDone); end
        n_checks++; if (FrameCnt !== 8'd1) begin n_fail++; $display("FAIL full_framecnt: got %0d want 1", FrameCnt); end
        n_checks++; if (DispBank !== 1'b1) begin n_fail++; $display("FAIL full_dispbank: got %b want 1", DispBank); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL full_busy: got %b want 0", Busy); end
        step(1, 0, 0, 12'h000);
        n_checks++; if (FrameDone !== 1'b0) begin n_fail++; $display("FAIL full_done_width: got %b want 0", FrameDone); end
        n_checks++; if (done_seen - d0 != 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", done_seen - d0); end
        rd(16'h0000);
        n_checks++; if (RdData !== 12'h001) begin n_fail++; $display("FAIL full_rd_first: got %h want 001", RdData); end
        rd(16'(FW - 1));
        n_checks++; if (RdData !== 12'(FW)) begin n_fail++; $display("FAIL full_rd_last: got %h want %h", RdData, 12'(FW)); end
    endtask

    task automatic test_gapped();
        int d0 = done_seen;
        for (int w = 0; w < FW; w++) begin
            step(1, 1, w == 0, 12'($urandom));
            n_checks++; if (Busy !== m_active) begin n_fail++; $display("FAIL gap_busy_word%0d: got %b want %b", w, Busy, m_active); end
            if (w < FW - 1) begin
                repeat (2) begin
                    step(1, 0, 1'($urandom), 12'($urandom));
                    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy_idle%0d: got %b want 1", w, Busy); end
                end
            end
        end
        n_checks++; if (done_seen - d0 != 1) begin n_fail++; $display("FAIL gap_done_count: got %0d want 1", done_seen - d0); end
        n_checks++; if (DispBank !== m_disp) begin n_fail++; $display("FAIL gap_dispbank: got %b want %b", DispBank, m_disp); end
        n_checks++; if (FrameCnt !== CW'(m_cnt)) begin n_fail++; $display("FAIL gap_framecnt: got %0d want %0d", FrameCnt, m_cnt); end
        for (int i = 0; i < 6; i++) begin
            int a = $urandom_range(0, FW - 1);
            rd(16'(a));
            n_checks++; if (RdData !== m_bank[m_disp][a]) begin n_fail++; $display("FAIL gap_rd[%0d]: got %h want %h", a, RdData, m_bank[m_disp][a]); end
        end
    endtask

    task automatic test_early_start();
        bit disp0 = m_disp;
        int d0 = done_seen;
        int e0 = m_err;
        step(1, 1, 1, 12'($urandom));
        for (int k = 0; k < FW / 2; k++) step(1, 1, 0, 12'($urandom));
        step(1, 1, 1, 12'($urandom));
        n_checks++; if (ErrCnt !== CW'(e0 + 1)) begin n_fail++; $display("FAIL early_errcnt: got %0d want %0d", ErrCnt, e0 + 1); end
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL early_busy: got %b want 1", Busy); end
        for (int k = 1; k < FW - 1; k++) step(1, 1, 0, 12'($urandom));
        step(1, 1, 1, 12'($urandom));
        n_checks++; if (ErrCnt !== CW'(e0 + 2)) begin n_fail++; $display("FAIL lastword_start_err: got %0d want %0d", ErrCnt, e0 + 2); end
        n_checks++; if (DispBank !== disp0 || done_seen != d0) begin n_fail++; $display("FAIL lastword_no_commit: bank %b done %0d want bank %b done 0", DispBank, done_seen - d0, disp0); end
        for (int k = 1; k < FW; k++) step(1, 1, 0, 12'($urandom));
        n_checks++; if (done_seen - d0 != 1 || DispBank !== !disp0) begin n_fail++; $display("FAIL early_then_commit: done %0d bank %b want 1 %b", done_seen - d0, DispBank, !disp0); end
        n_checks++; if (FrameCnt !== CW'(m_cnt)) begin n_fail++; $display("FAIL early_framecnt: got %0d want %0d", FrameCnt, m_cnt); end
        for (int i = 0; i < 4; i++) begin
            int a = $urandom_range(0, FW - 1);
            rd(16'(a));
            n_checks++; if (RdData !== m_bank[m_disp][a]) begin n_fail++; $display("FAIL early_rd[%0d]: got %h want %h", a, RdData, m_bank[m_disp][a]); end
        end
    endtask

    task automatic test_drop();
        int d0 = done_seen;
        step(1, 1, 1, 12'($urandom));
        for (int k = 0; k < 10; k++) step(1, 1, 0, 12'($urandom));
        step(0, 1, 0, 12'($urandom));
        n_checks++; if (ErrCnt !== CW'(m_err)) begin n_fail++; $display("FAIL drop_errcnt: got %0d want %0d", ErrCnt, m_err); end
        for (int k = 0; k < 5; k++) begin
            step(0, 1'($urandom), 1'($urandom), 12'($urandom));
            n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy_linkdown%0d: got %b want 0", k, Busy); end
        end
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 0, 12'($urandom));
            n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy_nostart%0d: got %b want 0", k, Busy); end
        end
        send_frame(0);
        n_checks++; if (done_seen - d0 != 1 || DispBank !== m_disp) begin n_fail++; $display("FAIL drop_recover: done %0d bank %b want 1 %b", done_seen - d0, DispBank, m_disp); end
        for (int i = 0; i < 4; i++) begin
            int a = $urandom_range(0, FW - 1);
            rd(16'(a));
            n_checks++; if (RdData !== m_bank[m_disp][a]) begin n_fail++; $display("FAIL drop_rd[%0d]: got %h want %h", a, RdData, m_bank[m_disp][a]); end
        end
    endtask

    task automatic test_read_range();
        rd(16'(FW - 1));
        n_checks++; if (RdData !== m_bank[m_disp][FW - 1]) begin n_fail++; $display("FAIL range_last: got %h want %h", RdData, m_bank[m_disp][FW - 1]); end
        rd(16'(FW));
        n_checks++; if (RdData !== 12'h000) begin n_fail++; $display("FAIL range_depth: got %h want 000", RdData); end
        rd(16'hFFFF);
        n_checks++; if (RdData !== 12'h000) begin n_fail++; $display("FAIL range_ffff: got %h want 000", RdData); end
    endtask

    task automatic test_err_sat();
        step(1, 1, 1, 12'($urandom));
        for (int k = 0; k < 300; k++) step(1, 1, 1, 12'($urandom));
        n_checks++; if (ErrCnt !== CW'(m_err) || m_err != 255) begin n_fail++; $display("FAIL err_saturate: got %0d want %0d", ErrCnt, m_err); end
        for (int k = 1; k < FW; k++) step(1, 1, 0, 12'($urandom));
        n_checks++; if (ErrCnt !== 8'hFF) begin n_fail++; $display("FAIL err_hold: got %0d want 255", ErrCnt); end
    endtask

    task automatic test_mid_reset();
        RdAdd = 16'h0001;
        step(1, 1, 1, 12'($urandom));
        for (int k = 0; k < FW / 2; k++) step(1, 1, 0, 12'($urandom));
        #2 rstn = 1'b0;
        model_reset();
        #1;
        n_checks++; if (RdData !== 12'h000) begin n_fail++; $display("FAIL midrst_rddata: got %h want 000", RdData); end
        n_checks++; if (DispBank !== 1'b0) begin n_fail++; $display("FAIL midrst_dispbank: got %b want 0", DispBank); end
        n_checks++; if (FrameCnt !== '0 || ErrCnt !== '0) begin n_fail++; $display("FAIL midrst_counts: got %0d %0d want 0 0", FrameCnt, ErrCnt); end
        n_checks++; if (Busy !== 1'b0 || FrameDone !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_done: got %b %b want 0 0", Busy, FrameDone); end
        @(posedge Cclk);
        #4 rstn = 1'b1;
        send_frame(0);
        n_checks++; if (DispBank !== 1'b1 || FrameCnt !== 8'd1) begin n_fail++; $display("FAIL midrst_commit: bank %b cnt %0d want 1 1", DispBank, FrameCnt); end
        for (int i = 0; i < 4; i++) begin
            int a = $urandom_range(0, FW - 1);
            rd(16'(a));
            n_checks++; if (RdData !== m_bank[1][a]) begin n_fail++; $display("FAIL midrst_rd[%0d]: got %h want %h", a, RdData, m_bank[1][a]); end
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        @(negedge Cclk) rstn = 1'b0;
        model_reset();
        @(negedge Cclk) rstn = 1'b1;
        d0 = done_seen;
        for (int f = 0; f < 256; f++) send_frame(0);
        n_checks++; if (FrameCnt !== CW'(m_cnt) || FrameCnt !== '0) begin n_fail++; $display("FAIL wrap_framecnt: got %0d want 0", FrameCnt); end
        n_checks++; if (done_seen - d0 != 256) begin n_fail++; $display("FAIL wrap_done_count: got %0d want 256", done_seen - d0); end
        n_checks++; if (DispBank !== m_disp) begin n_fail++; $display("FAIL wrap_dispbank: got %b want %b", DispBank, m_disp); end
        for (int i = 0; i < 4; i++) begin
            int a = $urandom_range(0, FW - 1);
            rd(16'(a));
            n_checks++; if (RdData !== m_bank[m_disp][a]) begin n_fail++; $display("FAIL wrap_rd[%0d]: got %h want %h", a, RdData, m_bank[m_disp][a]); end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gapped();
        test_early_start();
        test_drop();
        test_read_range();
        test_err_sat();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
